// File: rtl/multicycle_control_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_pkg
// Description : Shared definitions for the multicycle MIPS control path:
//               FSM state codes, opcode constants, ALUOp codes (also used
//               by ALUControl) and the bundled control-word type.
// Revision    : 1.0 - initial release
// ============================================================================
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RCOMP  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
  } state_t;

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_BNE   = 6'b000101;
  localparam logic [5:0] c_OP_J     = 6'b000010;

  localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
  localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
  localparam logic [1:0] c_ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic [1:0] pc_source;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/multicycle_control_output_decode.sv
`default_nettype none
// ============================================================================
// Module      : mc_output_decode
// Description : Purely combinational Moore decode of the FSM state into the
//               datapath control word. mem_ready only qualifies the FETCH
//               writes of IR and PC.
// Ports       : state     - current FSM state
//               mem_ready - memory completes access this cycle
//               ctrl      - bundled control outputs
// Revision    : 1.0 - initial release
// ============================================================================
import multicycle_control_pkg::*;

module mc_output_decode (
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.alu_op    = c_ALUOP_ADD;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = 2'b11;
        ctrl.alu_op    = c_ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = c_ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = c_ALUOP_FUNCT;
      end
      S_RCOMP: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = c_ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 2'b01;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = 2'b10;
      end
      default: ctrl = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Multicycle MIPS main control FSM with retired-instruction
//               counter. Optional bne support via macro MC_BNE_EN.
// Ports       : clk, rst (sync, active high), opcode (IR[31:26]), mem_ready
//               control outputs PCWrite..RegDst, PCSource, ALUSrcB, ALUOp,
//               branch_ne, illegal_op, state (current), retired (count)
// Revision    : 1.0 - initial release
// ============================================================================
import multicycle_control_pkg::*;

module multicycle_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             IRWrite,
  output logic             ALUSrcA,
  output logic             RegWrite,
  output logic             RegDst,
  output logic [1:0]       PCSource,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             branch_ne,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  state_t           r_state;
  state_t           w_next;
  logic [5:0]       r_op;
  logic [CNT_W-1:0] r_retired;
  logic             w_retire;
  logic             w_illegal;
  ctrl_t            w_ctrl;
  ctrl_t            w_ctrl_g;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_retired <= '0;
      r_op      <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_retired <= r_retired + CNT_W'(1);
      // Keep the decoded opcode so MEMADR/BRANCH do not depend on IR later.
      if (r_state == S_DECODE) r_op <= opcode;
    end
  end

  always_comb begin
    w_next    = S_FETCH;
    w_retire  = 1'b0;
    w_illegal = 1'b0;
    case (r_state)
      S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          c_OP_LW, c_OP_SW: w_next = S_MEMADR;
          c_OP_RTYPE:       w_next = S_EXEC;
          c_OP_BEQ:         w_next = S_BRANCH;
`ifdef MC_BNE_EN
          c_OP_BNE:         w_next = S_BRANCH;
`endif
          c_OP_J:           w_next = S_JUMP;
          default: begin
            w_next    = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: w_next = (r_op == c_OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  w_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      S_MEMWR: begin
        w_next   = mem_ready ? S_FETCH : S_MEMWR;
        w_retire = mem_ready;
      end
      S_EXEC:   w_next = S_RCOMP;
      S_RCOMP, S_BRANCH, S_JUMP: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      default:  w_next = S_FETCH;
    endcase
  end

  mc_output_decode u_output_decode (
    .state     (r_state),
    .mem_ready (mem_ready),
    .ctrl      (w_ctrl)
  );

  // Outputs are squashed combinationally so they are quiet in the very
  // cycle reset is raised, not only after the next edge.
  assign w_ctrl_g = rst ? '0 : w_ctrl;

  assign PCWrite     = w_ctrl_g.pc_write;
  assign PCWriteCond = w_ctrl_g.pc_write_cond;
  assign IorD        = w_ctrl_g.i_or_d;
  assign MemRead     = w_ctrl_g.mem_read;
  assign MemWrite    = w_ctrl_g.mem_write;
  assign MemtoReg    = w_ctrl_g.mem_to_reg;
  assign IRWrite     = w_ctrl_g.ir_write;
  assign ALUSrcA     = w_ctrl_g.alu_src_a;
  assign RegWrite    = w_ctrl_g.reg_write;
  assign RegDst      = w_ctrl_g.reg_dst;
  assign PCSource    = w_ctrl_g.pc_source;
  assign ALUSrcB     = w_ctrl_g.alu_src_b;
  assign ALUOp       = w_ctrl_g.alu_op;

  assign illegal_op  = w_illegal & ~rst;

`ifdef MC_BNE_EN
  assign branch_ne   = (r_state == S_BRANCH) && (r_op == c_OP_BNE) && !rst;
`else
  assign branch_ne   = 1'b0;
`endif

  assign state   = r_state;
  assign retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control
// Description : Directed self-checking bench for multicycle_control with
//               CNT_W=4 so the retired counter wrap is reachable.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic             IRWrite, ALUSrcA, RegWrite, RegDst;
  logic [1:0]       PCSource, ALUSrcB, ALUOp;
  logic             branch_ne, illegal_op;
  logic [3:0]       state;
  logic [CNT_W-1:0] retired;

  int               n_vec;
  int               n_err;
  logic [CNT_W-1:0] exp_ret;

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .PCSource(PCSource), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .branch_ne(branch_ne), .illegal_op(illegal_op), .state(state),
    .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0; n_err = 0; exp_ret = '0;
    rst = 1'b1; opcode = 6'b000000; mem_ready = 1'b0;

    // Reset state and forced-zero outputs while rst is high
    step();
    chk("rst_state", state, 4'd0);
    chk("rst_retired", retired, 0);
    chk("rst_memread", MemRead, 1'b0);
    chk("rst_alusrcb", ALUSrcB, 2'b00);

    // Release; FETCH waits on mem_ready
    rst = 1'b0; #1;
    chk("fetch_memread", MemRead, 1'b1);
    chk("fetch_alusrcb", ALUSrcB, 2'b01);
    chk("fetch_irwrite_lo", IRWrite, 1'b0);
    step();
    chk("fetch_hold", state, 4'd0);
    mem_ready = 1'b1; #1;
    chk("fetch_irwrite_hi", IRWrite, 1'b1);
    chk("fetch_pcwrite_hi", PCWrite, 1'b1);

    // R-type: 0,1,6,7,0
    step();
    chk("r_decode", state, 4'd1);
    chk("r_dec_alusrcb", ALUSrcB, 2'b11);
    step();
    chk("r_exec", state, 4'd6);
    chk("r_exec_aluop", ALUOp, 2'b10);
    chk("r_exec_alusrca", ALUSrcA, 1'b1);
    step();
    chk("r_rcomp", state, 4'd7);
    chk("r_rcomp_regwrite", RegWrite, 1'b1);
    chk("r_rcomp_regdst", RegDst, 1'b1);
    step();
    exp_ret = exp_ret + 1'b1;
    chk("r_fetch", state, 4'd0);
    chk("r_retired", retired, 32'(exp_ret));

    // lw with 3 wait cycles in MEMRD; opcode changes after DECODE
    opcode = 6'b100011;
    step();
    chk("lw_decode", state, 4'd1);
    step();
    chk("lw_memadr", state, 4'd2);
    chk("lw_memadr_alusrcb", ALUSrcB, 2'b10);
    opcode = 6'b101011;
    step();
    chk("lw_memrd", state, 4'd3);
    chk("lw_memrd_iord", IorD, 1'b1);
    chk("lw_memrd_memread", MemRead, 1'b1);
    mem_ready = 1'b0;
    step();
    chk("lw_memrd_hold2", state, 4'd3);
    step();
    chk("lw_memrd_hold3", state, 4'd3);
    step();
    chk("lw_memrd_hold4", state, 4'd3);
    mem_ready = 1'b1;
    step();
    chk("lw_memwb", state, 4'd4);
    chk("lw_memwb_memtoreg", MemtoReg, 1'b1);
    chk("lw_memwb_regwrite", RegWrite, 1'b1);
    chk("lw_memwb_retired", retired, 32'(exp_ret));
    step();
    exp_ret = exp_ret + 1'b1;
    chk("lw_fetch", state, 4'd0);
    chk("lw_retired", retired, 32'(exp_ret));

    // Illegal opcode
    opcode = 6'b111111;
    step();
    chk("ill_decode", state, 4'd1);
    chk("ill_pulse", illegal_op, 1'b1);
    step();
    chk("ill_fetch", state, 4'd0);
    chk("ill_pulse_gone", illegal_op, 1'b0);
    chk("ill_retired", retired, 32'(exp_ret));

    // beq
    opcode = 6'b000100;
    step();
    step();
    chk("beq_branch", state, 4'd8);
    chk("beq_aluop", ALUOp, 2'b01);
    chk("beq_pcwritecond", PCWriteCond, 1'b1);
    chk("beq_pcsource", PCSource, 2'b01);
    chk("beq_branch_ne", branch_ne, 1'b0);
    step();
    exp_ret = exp_ret + 1'b1;
    chk("beq_retired", retired, 32'(exp_ret));

    // bne
    opcode = 6'b000101;
    step();
    chk("bne_decode", state, 4'd1);
`ifdef MC_BNE_EN
    chk("bne_not_illegal", illegal_op, 1'b0);
    step();
    chk("bne_branch", state, 4'd8);
    chk("bne_branch_ne", branch_ne, 1'b1);
    step();
    exp_ret = exp_ret + 1'b1;
    chk("bne_retired", retired, 32'(exp_ret));
`else
    chk("bne_illegal", illegal_op, 1'b1);
    step();
    chk("bne_fetch", state, 4'd0);
    chk("bne_branch_ne", branch_ne, 1'b0);
    chk("bne_retired", retired, 32'(exp_ret));
`endif

    // sw aborted by reset while in MEMWR
    opcode = 6'b101011;
    step();
    step();
    chk("sw_memadr", state, 4'd2);
    mem_ready = 1'b0;
    step();
    chk("sw_memwr", state, 4'd5);
    chk("sw_memwrite", MemWrite, 1'b1);
    chk("sw_iord", IorD, 1'b1);
    step();
    chk("sw_memwr_hold", state, 4'd5);
    rst = 1'b1; mem_ready = 1'b1; #1;
    chk("sw_rst_memwrite", MemWrite, 1'b0);
    chk("sw_rst_iord", IorD, 1'b0);
    step();
    chk("sw_rst_state", state, 4'd0);
    chk("sw_rst_memread", MemRead, 1'b0);
    chk("sw_rst_retired", retired, 0);
    rst = 1'b0; mem_ready = 1'b0; #1;
    chk("sw_rel_memwrite", MemWrite, 1'b0);
    step();
    chk("sw_rel_state", state, 4'd0);
    chk("sw_rel_memwrite2", MemWrite, 1'b0);

    // Jumps: 15 bring retired to all-ones, the 16th wraps it to 0
    exp_ret = '0;
    opcode = 6'b000010;
    mem_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      step();
      if (i == 0) begin
        chk("j_state", state, 4'd9);
        chk("j_pcwrite", PCWrite, 1'b1);
        chk("j_pcsource", PCSource, 2'b10);
      end
      step();
      exp_ret = exp_ret + 1'b1;
      if (i == 14) chk("j_allones", retired, 32'hF);
    end
    chk("j_wrap", retired, 0);
    chk("j_wrap_model", retired, 32'(exp_ret));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
